// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Central stall/flush scheduler for the 5-stage pipeline. Drives
//             the PC register and the four inter-stage registers, arbitrates
//             bus waits, multi-cycle MDU, load-use hazards and EX redirects,
//             and tracks one outstanding fetch so that a stale response
//             arriving after a redirect is dropped.
//  Options  : PIPE_HAZARD_PERF_EN - adds stall/flush performance counters.
//             When undefined, the counter ports are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int PERF_W = 32
) (
   input  logic              clk,
   input  logic              reset,          // asynchronous, active-low
   input  logic              ibus_req,
   input  logic              ibus_ok,
   input  logic              dbus_req,
   input  logic              dbus_ok,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use1,
   input  logic              id_use2,
   input  logic              ex_mdu_start,
   input  logic              ex_mdu_done,
   input  logic              ex_redirect,
   output logic              stall_pc,
   output logic              stall_fd,
   output logic              stall_de,
   output logic              stall_em,
   output logic              stall_mw,
   output logic              flush_fd,
   output logic              flush_de,
   output logic              flush_em,
   output logic              flush_mw,
   output logic              redirect_take,
   output logic              fetch_discard,
   output logic [PERF_W-1:0] perf_stall_cnt,
   output logic [PERF_W-1:0] perf_flush_cnt
);

   typedef enum logic [1:0] {
      F_IDLE    = 2'd0,
      F_WAIT    = 2'd1,
      F_DISCARD = 2'd2
   } fetch_state_t;

   typedef enum logic [0:0] {
      M_IDLE = 1'b0,
      M_BUSY = 1'b1
   } mdu_state_t;

   fetch_state_t fetch_state_q, fetch_state_d;
   mdu_state_t   mdu_state_q,   mdu_state_d;

   logic w_mem_wait;
   logic w_mdu_wait;
   logic w_load_use;
   logic w_fetch_wait;
   logic w_stale_rsp;
   logic w_rs1_hit;
   logic w_rs2_hit;

   // Hazard conditions derived from the current inputs and FSM state.
   always_comb begin
      w_mem_wait   = dbus_req & ~dbus_ok;
      w_mdu_wait   = ((mdu_state_q == M_BUSY) | ex_mdu_start) & ~ex_mdu_done;
      w_rs1_hit    = id_use1 & (id_rs1 == ex_rd);
      w_rs2_hit    = id_use2 & (id_rs2 == ex_rd);
      // x0 is hardwired to zero, so a load into it never creates a hazard.
      w_load_use   = ex_is_load & (ex_rd != '0) & (w_rs1_hit | w_rs2_hit);
      w_fetch_wait = ibus_req & ~ibus_ok;
      w_stale_rsp  = (fetch_state_q == F_DISCARD) & ibus_ok;
   end

   // Priority resolution of stall/flush controls; everything is forced low
   // while reset is asserted. A stalled register ignores flush, so each row
   // inserts its bubble in the first register downstream of the hold.
   always_comb begin
      stall_pc      = 1'b0;
      stall_fd      = 1'b0;
      stall_de      = 1'b0;
      stall_em      = 1'b0;
      stall_mw      = 1'b0;
      flush_fd      = 1'b0;
      flush_de      = 1'b0;
      flush_em      = 1'b0;
      flush_mw      = 1'b0;
      redirect_take = 1'b0;
      fetch_discard = 1'b0;
      if (reset) begin
         fetch_discard = w_stale_rsp;
         if (w_mem_wait) begin
            stall_pc = 1'b1;
            stall_fd = 1'b1;
            stall_de = 1'b1;
            stall_em = 1'b1;
            flush_mw = 1'b1;
         end else if (w_mdu_wait) begin
            stall_pc = 1'b1;
            stall_fd = 1'b1;
            stall_de = 1'b1;
            flush_em = 1'b1;
         end else if (w_load_use) begin
            stall_pc = 1'b1;
            stall_fd = 1'b1;
            flush_de = 1'b1;
         end else if (ex_redirect) begin
            // Held EX re-presents the redirect later if a higher row wins.
            redirect_take = 1'b1;
            flush_fd      = 1'b1;
            flush_de      = 1'b1;
         end else if (w_fetch_wait | w_stale_rsp) begin
            stall_pc = 1'b1;
            flush_fd = 1'b1;
         end
      end
   end

   // MDU tracker next state: busy from an accepted start until done.
   always_comb begin
      mdu_state_d = mdu_state_q;
      case (mdu_state_q)
         M_IDLE: begin
            // A start that completes in its own cycle never goes busy; a
            // start under a memory wait is re-issued once EX advances.
            if (ex_mdu_start & ~ex_mdu_done & ~w_mem_wait) begin
               mdu_state_d = M_BUSY;
            end
         end
         M_BUSY: begin
            if (ex_mdu_done) begin
               mdu_state_d = M_IDLE;
            end
         end
         default: mdu_state_d = M_IDLE;
      endcase
   end

   // Fetch tracker next state: follows the single outstanding ibus request
   // and marks it stale when a redirect overtakes it.
   always_comb begin
      fetch_state_d = fetch_state_q;
      case (fetch_state_q)
         F_IDLE: begin
            if (w_fetch_wait) begin
               fetch_state_d = F_WAIT;
            end
         end
         F_WAIT: begin
            // A response that lands with the redirect is already killed by
            // flush_fd, so nothing remains to discard.
            if (ibus_ok) begin
               fetch_state_d = F_IDLE;
            end else if (redirect_take) begin
               fetch_state_d = F_DISCARD;
            end
         end
         F_DISCARD: begin
            // Only one request is ever outstanding, so a further redirect
            // here changes nothing: the next response is still the stale one.
            if (ibus_ok) begin
               fetch_state_d = F_IDLE;
            end
         end
         default: fetch_state_d = F_IDLE;
      endcase
   end

   // FSM state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mdu_state_q   <= M_IDLE;
         fetch_state_q <= F_IDLE;
      end else begin
         mdu_state_q   <= mdu_state_d;
         fetch_state_q <= fetch_state_d;
      end
   end

`ifdef PIPE_HAZARD_PERF_EN
   logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
   logic [PERF_W-1:0] perf_flush_q, perf_flush_d;
   logic              w_any_flush;

   // Counter increments; both wrap naturally at 2^PERF_W.
   always_comb begin
      w_any_flush  = flush_fd | flush_de | flush_em | flush_mw;
      perf_stall_d = perf_stall_q;
      perf_flush_d = perf_flush_q;
      if (stall_pc) begin
         perf_stall_d = perf_stall_q + PERF_W'(1);
      end
      if (w_any_flush) begin
         perf_flush_d = perf_flush_q + PERF_W'(1);
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
      end
   end

   assign perf_stall_cnt = perf_stall_q;
   assign perf_flush_cnt = perf_flush_q;
`else
   assign perf_stall_cnt = '0;
   assign perf_flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Purpose  : Self-checking bench for pipeline_hazard_ctrl: a table of
//             single-cycle combinational vectors plus hand-written sequences
//             for the multi-cycle MDU, fetch-discard, blocked-redirect and
//             mid-operation reset cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

   localparam int REG_AW = 5;
   localparam int PERF_W = 32;
`ifdef PIPE_HAZARD_PERF_EN
   localparam int PERF_ON = 1;
`else
   localparam int PERF_ON = 0;
`endif

   // Observed order: {stall_pc, stall_fd, stall_de, stall_em, stall_mw,
   //                  flush_fd, flush_de, flush_em, flush_mw,
   //                  redirect_take, fetch_discard}
   localparam logic [10:0] NONE = 11'b00000_0000_00;
   localparam logic [10:0] R1   = 11'b11110_0001_00;
   localparam logic [10:0] R2   = 11'b11100_0010_00;
   localparam logic [10:0] R3   = 11'b11000_0100_00;
   localparam logic [10:0] R4   = 11'b00000_1100_10;
   localparam logic [10:0] R5   = 11'b10000_1000_00;
   localparam logic [10:0] DISC = 11'b10000_1000_01;

   logic              clk;
   logic              reset;
   logic              ibus_req, ibus_ok, dbus_req, dbus_ok, ex_is_load;
   logic [REG_AW-1:0] ex_rd, id_rs1, id_rs2;
   logic              id_use1, id_use2, ex_mdu_start, ex_mdu_done, ex_redirect;
   logic              stall_pc, stall_fd, stall_de, stall_em, stall_mw;
   logic              flush_fd, flush_de, flush_em, flush_mw;
   logic              redirect_take, fetch_discard;
   logic [PERF_W-1:0] perf_stall_cnt, perf_flush_cnt;
   logic [10:0]       obs;

   int n_checks = 0;
   int n_fail   = 0;

   pipeline_hazard_ctrl #(.REG_AW(REG_AW), .PERF_W(PERF_W)) dut (
      .clk(clk), .reset(reset),
      .ibus_req(ibus_req), .ibus_ok(ibus_ok),
      .dbus_req(dbus_req), .dbus_ok(dbus_ok),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use1(id_use1), .id_use2(id_use2),
      .ex_mdu_start(ex_mdu_start), .ex_mdu_done(ex_mdu_done),
      .ex_redirect(ex_redirect),
      .stall_pc(stall_pc), .stall_fd(stall_fd), .stall_de(stall_de),
      .stall_em(stall_em), .stall_mw(stall_mw),
      .flush_fd(flush_fd), .flush_de(flush_de), .flush_em(flush_em),
      .flush_mw(flush_mw),
      .redirect_take(redirect_take), .fetch_discard(fetch_discard),
      .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
   );

   assign obs = {stall_pc, stall_fd, stall_de, stall_em, stall_mw,
                 flush_fd, flush_de, flush_em, flush_mw,
                 redirect_take, fetch_discard};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        dr, dok, ir, iok, ld;
      logic [4:0]  rd, rs1, rs2;
      logic        u1, u2, ms, md, rdr;
      logic [10:0] exp;
   } vec_t;

   vec_t tbl[17];

   function automatic vec_t mk(input logic dr, dok, ir, iok, ld,
                               input logic [4:0] rd, rs1, rs2,
                               input logic u1, u2, ms, md, rdr,
                               input logic [10:0] exp);
      vec_t v;
      v.dr = dr; v.dok = dok; v.ir = ir; v.iok = iok; v.ld = ld;
      v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.u1 = u1; v.u2 = u2; v.ms = ms; v.md = md; v.rdr = rdr;
      v.exp = exp;
      return v;
   endfunction

   task automatic idle();
      dbus_req = 0; dbus_ok = 0; ibus_req = 0; ibus_ok = 0; ex_is_load = 0;
      ex_rd = '0; id_rs1 = '0; id_rs2 = '0; id_use1 = 0; id_use2 = 0;
      ex_mdu_start = 0; ex_mdu_done = 0; ex_redirect = 0;
   endtask

   task automatic apply(input vec_t v);
      dbus_req = v.dr; dbus_ok = v.dok; ibus_req = v.ir; ibus_ok = v.iok;
      ex_is_load = v.ld; ex_rd = v.rd; id_rs1 = v.rs1; id_rs2 = v.rs2;
      id_use1 = v.u1; id_use2 = v.u2; ex_mdu_start = v.ms;
      ex_mdu_done = v.md; ex_redirect = v.rdr;
   endtask

   task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic check_cnt(input string nm, input logic [PERF_W-1:0] act, input int exp);
      n_checks++;
      if (act !== PERF_W'(exp)) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   initial begin
      // single-cycle vectors, each applied from the idle FSM state
      tbl[0]  = mk(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0,0, NONE);
      tbl[1]  = mk(1,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0,0, R1);
      tbl[2]  = mk(1,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0,0, NONE);
      tbl[3]  = mk(1,0,0,0,1, 5'd5,5'd0,5'd5, 0,1,1,0,1, R1);
      tbl[4]  = mk(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,1,0,0, R2);
      tbl[5]  = mk(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,1,1,0, NONE);
      tbl[6]  = mk(0,0,0,0,1, 5'd5,5'd0,5'd5, 0,1,0,0,0, R3);
      tbl[7]  = mk(0,0,0,0,1, 5'd0,5'd0,5'd0, 0,1,0,0,0, NONE);
      tbl[8]  = mk(0,0,0,0,1, 5'd7,5'd7,5'd0, 0,0,0,0,0, NONE);
      tbl[9]  = mk(0,0,0,0,1, 5'd7,5'd7,5'd0, 1,0,0,0,1, R3);
      tbl[10] = mk(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0,1, R4);
      tbl[11] = mk(0,0,1,0,0, 5'd0,5'd0,5'd0, 0,0,0,0,1, R4);
      tbl[12] = mk(0,0,1,0,0, 5'd0,5'd0,5'd0, 0,0,0,0,0, R5);
      tbl[13] = mk(0,0,1,1,0, 5'd0,5'd0,5'd0, 0,0,0,0,0, NONE);
      tbl[14] = mk(0,0,0,0,1, 5'd3,5'd3,5'd0, 1,0,1,0,0, R2);
      tbl[15] = mk(0,0,0,0,0, 5'd3,5'd3,5'd0, 1,0,0,0,0, NONE);
      tbl[16] = mk(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,1,0, NONE);

      // reset state: outputs gated low even with a hazard on the inputs
      idle();
      reset = 1'b0;
      dbus_req = 1;
      #1;
      check("reset_outputs", obs, NONE);
      check_cnt("reset_stall_cnt", perf_stall_cnt, 0);
      check_cnt("reset_flush_cnt", perf_flush_cnt, 0);
      idle();
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // table: drive, sample combinationally, return to idle before posedge
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         apply(tbl[i]);
         #1;
         check($sformatf("vec%0d", i), obs, tbl[i].exp);
         #1;
         idle();
      end

      // memory wait for three cycles, then the ok cycle
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         dbus_req = 1; dbus_ok = 0;
         #1 check($sformatf("memwait_c%0d", k), obs, R1);
      end
      @(negedge clk);
      dbus_ok = 1;
      #1 check("memwait_ok", obs, NONE);
      @(negedge clk);
      idle();

      // MDU: start pulse, done four cycles later
      @(negedge clk);
      ex_mdu_start = 1;
      #1 check("mdu_c0", obs, R2);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         ex_mdu_start = 0;
         #1 check($sformatf("mdu_c%0d", k), obs, R2);
      end
      @(negedge clk);
      ex_mdu_done = 1;
      #1 check("mdu_done", obs, NONE);
      @(negedge clk);
      ex_mdu_done = 0;
      #1 check("mdu_back_idle", obs, NONE);

      // fetch outstanding, redirect overtakes it, stale response discarded
      @(negedge clk);
      ibus_req = 1; ibus_ok = 0;
      #1 check("fetch_wait", obs, R5);
      @(negedge clk);
      ex_redirect = 1;
      #1 check("fetch_redirect", obs, R4);
      @(negedge clk);
      ex_redirect = 0; ibus_req = 0;
      #1 check("discard_pending", obs, NONE);
      @(negedge clk);
      ibus_ok = 1;
      #1 check("discard_ok", obs, DISC);
      @(negedge clk);
      #1 check("discard_back_idle", obs, NONE);
      @(negedge clk);
      idle();

      // redirect blocked by memory wait until it clears
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         dbus_req = 1; dbus_ok = 0; ex_redirect = 1;
         #1 check($sformatf("redir_blocked_c%0d", k), obs, R1);
      end
      @(negedge clk);
      dbus_ok = 1;
      #1 check("redir_taken", obs, R4);
      @(negedge clk);
      idle();

      // reset mid-MDU-busy with both counters at 7
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      ex_mdu_start = 1;
      #1 check("perf_mdu_c0", obs, R2);
      for (int k = 1; k < 7; k++) begin
         @(negedge clk);
         ex_mdu_start = 0;
         #1 check($sformatf("perf_mdu_c%0d", k), obs, R2);
      end
      @(negedge clk);
      #1;
      check_cnt("stall_cnt_7", perf_stall_cnt, 7 * PERF_ON);
      check_cnt("flush_cnt_7", perf_flush_cnt, 7 * PERF_ON);
      check("busy_before_reset", obs, R2);
      #1 reset = 1'b0;
      #1;
      check("async_reset_outputs", obs, NONE);
      check_cnt("async_reset_stall_cnt", perf_stall_cnt, 0);
      check_cnt("async_reset_flush_cnt", perf_flush_cnt, 0);
      @(negedge clk);
      reset = 1'b1;
      #1 check("mdu_idle_after_reset", obs, NONE);
      @(negedge clk);
      dbus_req = 1; dbus_ok = 0;
      #1 check("resume_memwait", obs, R1);
      @(negedge clk);
      idle();
      #1;
      check_cnt("resume_stall_cnt", perf_stall_cnt, PERF_ON);
      check_cnt("resume_flush_cnt", perf_flush_cnt, PERF_ON);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
